voltage_update_scheduler: RTL and testbench

VOLTAGE_UPDATE_SCHEDULER -- requirements
Module: voltage_update_scheduler

---
 rtl/voltage_update_scheduler_pkg.sv | 21 ++
 rtl/voltage_update_scheduler_alu.sv | 51 +++++
 rtl/voltage_update_scheduler.sv | 146 ++++++++++++++
 tb/tb_voltage_update_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voltage_update_scheduler_pkg.sv
// Shared definitions for the voltage update scheduler: FSM state encoding,
// the signed 16-bit membrane-voltage type and its saturation limits.
package voltage_update_scheduler_pkg;

    localparam int VOL_W = 16;

    typedef logic signed [VOL_W-1:0] vol_t;

    localparam vol_t VOL_MAX = 16'sh7FFF;
    localparam vol_t VOL_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CALC,
        WR,
        CLR,
        FIN
    } state_t;

endpackage

// File: rtl/voltage_update_scheduler_alu.sv
// lif_update_alu: combinational neuron update.
//   sum     = saturate(pre_vol + diff) to the 16-bit signed range
//   fire    = sum >= VTH
//   new_vol = fire ? sum - VTH : sum, then minus (new_vol >>> LEAK_SHIFT)
//             when the LIF_LEAK_EN macro is defined
// Ports:
//   pre_vol  in   stored voltage
//   diff     in   input current
//   new_vol  out  updated voltage
//   fire     out  threshold crossed
module lif_update_alu
    import voltage_update_scheduler_pkg::*;
#(
    parameter logic signed [15:0] VTH        = 16'sd1024,
    parameter int                 LEAK_SHIFT = 4
) (
    input  logic signed [15:0] pre_vol,
    input  logic signed [15:0] diff,
    output logic signed [15:0] new_vol,
    output logic               fire
);

`ifdef LIF_LEAK_EN
    localparam bit LEAK_EN = 1'b1;
`else
    localparam bit LEAK_EN = 1'b0;
`endif

    // A 17-bit sum overflows the 16-bit range exactly when its top two bits differ.
    function automatic vol_t sat_add(input vol_t a, input vol_t b);
        logic signed [16:0] s;
        s = 17'(a) + 17'(b);
        if (s[16] != s[15]) begin
            return s[16] ? VOL_MIN : VOL_MAX;
        end
        return vol_t'(s[15:0]);
    endfunction

    vol_t sum;
    vol_t v_thr;
    vol_t leak;

    assign sum   = sat_add(pre_vol, diff);
    assign fire  = (sum >= VTH);
    // sum >= VTH when firing, so the subtraction cannot wrap.
    assign v_thr = fire ? (sum - VTH) : sum;
    // The leak term only shrinks the magnitude, so no saturation is needed.
    assign leak  = LEAK_EN ? (v_thr >>> LEAK_SHIFT) : '0;
    assign new_vol = v_thr - leak;

endmodule

// File: rtl/voltage_update_scheduler.sv
// voltage_update_scheduler: sweeps N_NEURON voltage-memory entries once per
// start request (read, combine with one input-current sample, write back,
// emit a spike on threshold crossing) or zeroes all entries on clear.
// Optional feature: define LIF_LEAK_EN to apply a leak after thresholding.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, clear       single-cycle sweep / clear requests (accepted in IDLE)
//   busy, done         activity flag, one-cycle completion pulse
//   in_valid, in_diff  input-current sample, in_ready accepts it
//   mem_wr_en, mem_addr, mem_post_vol, mem_vol_diff   memory write/read port
//   mem_pre_vol        read data, one cycle after the read address
//   spike_valid, spike_idx   firing event
module voltage_update_scheduler
    import voltage_update_scheduler_pkg::*;
#(
    parameter int                 N_NEURON   = 40,
    parameter int                 ADDR_W     = 6,
    parameter logic signed [15:0] VTH        = 16'sd1024,
    parameter int                 LEAK_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    input  logic signed [15:0]       in_diff,
    output logic                     in_ready,
    output logic                     mem_wr_en,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic signed [15:0]       mem_post_vol,
    output logic signed [15:0]       mem_vol_diff,
    input  logic signed [15:0]       mem_pre_vol,
    output logic                     spike_valid,
    output logic [ADDR_W-1:0]        spike_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURON - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              wr_req;

    vol_t alu_vol_p0;
    logic alu_fire_p0;
    vol_t v_new_p1;
    vol_t diff_p1;
    logic fire_p1;

    lif_update_alu #(
        .VTH        (VTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_alu (
        .pre_vol (mem_pre_vol),
        .diff    (in_diff),
        .new_vol (alu_vol_p0),
        .fire    (alu_fire_p0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // ---- p0 -> p1: result captured on the CALC handshake ----
    always_ff @(posedge clk) begin
        if (state == CALC && in_valid) begin
            v_new_p1 <= alu_vol_p0;
            diff_p1  <= in_diff;
            fire_p1  <= alu_fire_p0;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        busy         = 1'b1;
        done         = 1'b0;
        in_ready     = 1'b0;
        wr_req       = 1'b0;
        mem_addr     = idx;
        mem_post_vol = '0;
        mem_vol_diff = '0;
        spike_valid  = 1'b0;
        spike_idx    = '0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                mem_addr = '0;
                if (clear) begin
                    state_next = CLR;
                    idx_next   = '0;
                end else if (start) begin
                    state_next = RD;
                    idx_next   = '0;
                end
            end
            RD: begin
                state_next = CALC;
            end
            CALC: begin
                in_ready = 1'b1;
                if (in_valid) state_next = WR;
            end
            WR: begin
                wr_req       = 1'b1;
                mem_post_vol = v_new_p1;
                mem_vol_diff = diff_p1;
                spike_valid  = fire_p1;
                spike_idx    = fire_p1 ? idx : '0;
                if (idx == LAST_IDX) begin
                    state_next = FIN;
                end else begin
                    idx_next   = idx + 1'b1;
                    state_next = RD;
                end
            end
            CLR: begin
                wr_req = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = FIN;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            FIN: begin
                done       = 1'b1;
                mem_addr   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A reset arriving while a write is presented cancels that write at the same edge.
    assign mem_wr_en = wr_req & ~rst;

endmodule

// File: tb/tb_voltage_update_scheduler.sv
module tb_voltage_update_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               clear;
    logic               busy;
    logic               done;
    logic               in_valid;
    logic signed [15:0] in_diff;
    logic               in_ready;
    logic               mem_wr_en;
    logic [5:0]         mem_addr;
    logic signed [15:0] mem_post_vol;
    logic signed [15:0] mem_vol_diff;
    logic signed [15:0] mem_pre_vol;
    logic               spike_valid;
    logic [5:0]         spike_idx;

    always #5 clk = ~clk;

    voltage_update_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear        (clear),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_diff      (in_diff),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_post_vol (mem_post_vol),
        .mem_vol_diff (mem_vol_diff),
        .mem_pre_vol  (mem_pre_vol),
        .spike_valid  (spike_valid),
        .spike_idx    (spike_idx)
    );

    // Voltage memory model with one-cycle read latency and a preload port.
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr_en) mem[mem_addr] <= {mem_vol_diff, mem_post_vol};
        mem_pre_vol <= mem[mem_addr][15:0];
    end

    // Spike recorder
    bit spike_seen [64];
    int spike_cnt = 0;
    bit spike_clr = 1'b0;

    always @(negedge clk) begin
        if (spike_clr) begin
            foreach (spike_seen[i]) spike_seen[i] = 1'b0;
            spike_cnt = 0;
        end else if (spike_valid) begin
            spike_seen[spike_idx] = 1'b1;
            spike_cnt++;
        end
    end

    typedef struct {
        logic signed [15:0] pre;
        logic signed [15:0] diff;
        logic signed [15:0] post;
        bit                 fire;
    } vec_t;

    localparam int NV = 12;
    vec_t               tbl [NV];
    logic signed [15:0] diff_arr [64];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] exp_leak(input logic signed [15:0] v);
`ifdef LIF_LEAK_EN
        return v - (v >>> 4);
`else
        return v;
`endif
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = 6'(a);
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic pulse_spike_clr();
        spike_clr = 1'b1;
        @(negedge clk);
        spike_clr = 1'b0;
    endtask

    // Runs one sweep; stalls the first CALC for 'stall' cycles and pulses clear during it.
    task automatic run_sweep(input int stall, input int exp_lat, input string tag);
        int lat;
        int left;
        left  = stall;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        chk({tag, "_first_addr"}, mem_addr, 0);
        chk({tag, "_busy"}, busy, 1);
        while (!done && lat < 1000) begin
            if (in_ready && left > 0) begin
                chk({tag, "_stall_addr"}, mem_addr, 0);
                chk({tag, "_stall_wr"}, mem_wr_en, 0);
                clear    = (left == 5);
                in_valid = 1'b0;
                left--;
            end else begin
                clear    = 1'b0;
                in_valid = in_ready;
                in_diff  = in_ready ? diff_arr[mem_addr] : 16'sd0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        chk({tag, "_done_latency"}, lat, exp_lat);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int lat;
        int bad;
        int n;

        tbl[0]  = '{16'sd0,      16'sd100,   16'sd100,   1'b0};
        tbl[1]  = '{16'sd1023,   16'sd0,     16'sd1023,  1'b0};
        tbl[2]  = '{16'sd1024,   16'sd0,     16'sd0,     1'b1};
        tbl[3]  = '{16'sd32700,  16'sd200,   16'sd31743, 1'b1};
        tbl[4]  = '{-16'sd32700, -16'sd200,  16'sh8000,  1'b0};
        tbl[5]  = '{16'sd1000,   16'sd50,    16'sd26,    1'b1};
        tbl[6]  = '{-16'sd5,     16'sd3,     -16'sd2,    1'b0};
        tbl[7]  = '{16'sd500,    16'sd524,   16'sd0,     1'b1};
        tbl[8]  = '{16'sd32767,  16'sd32767, 16'sd31743, 1'b1};
        tbl[9]  = '{-16'sd1,     16'sh8000,  16'sh8000,  1'b0};
        tbl[10] = '{16'sd160,    16'sd0,     16'sd160,   1'b0};
        tbl[11] = '{16'sd2000,   16'sd100,   16'sd1076,  1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_diff  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_spike", spike_valid, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clear over junk contents
        for (int i = 0; i < 40; i++) preload(i, 32'(i * 37 + 5));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        lat   = 1;
        chk("clr_busy", busy, 1);
        chk("clr_wr_en", mem_wr_en, 1);
        chk("clr_data", mem_post_vol, 0);
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        chk("clr_done_latency", lat, 41);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 40; i++) if (mem[i] !== 32'h0) bad++;
        chk("clr_nonzero_entries", bad, 0);

        // Uniform sweep of 100
        pulse_spike_clr();
        for (int i = 0; i < 64; i++) diff_arr[i] = 16'sd100;
        run_sweep(0, 121, "sweep100");
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (mem[i] !== {16'd100, 16'(exp_leak(16'sd100))}) bad++;
        chk("sweep100_bad_entries", bad, 0);
        chk("sweep100_spikes", spike_cnt, 0);

        // Table-driven vectors, one neuron per record
        for (int i = 0; i < 40; i++) begin
            if (i < NV) begin
                preload(i, {16'h0, tbl[i].pre});
                diff_arr[i] = tbl[i].diff;
            end else begin
                preload(i, 32'h0);
                diff_arr[i] = 16'sd0;
            end
        end
        pulse_spike_clr();
        run_sweep(0, 121, "table");
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("vec%0d_post", i), $signed(mem[i][15:0]), exp_leak(tbl[i].post));
            chk($sformatf("vec%0d_diff", i), $signed(mem[i][31:16]), tbl[i].diff);
            chk($sformatf("vec%0d_spike", i), spike_seen[i], tbl[i].fire);
        end
        bad = 0;
        for (int i = NV; i < 40; i++) if (mem[i] !== 32'h0 || spike_seen[i]) bad++;
        chk("table_tail_bad", bad, 0);
        chk("table_spike_count", spike_cnt, 6);

        // Stall neuron 0 for 10 cycles with an ignored clear pulse
        for (int i = 0; i < 64; i++) diff_arr[i] = 16'sd1;
        run_sweep(10, 131, "stall");

        // Reset during the write of neuron 20
        preload(19, 32'h0);
        preload(20, 32'h0000_1234);
        for (int i = 0; i < 64; i++) diff_arr[i] = 16'sd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_wr_en && mem_addr == 6'd20) && n < 1000) begin
            in_valid = in_ready;
            in_diff  = in_ready ? diff_arr[mem_addr] : 16'sd0;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("rst_wr_reached", (n < 1000) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_wr_en", mem_wr_en, 0);
        chk("rstwr_addr", mem_addr, 0);
        chk("rstwr_entry20", mem[20], 32'h0000_1234);
        chk("rstwr_entry19", mem[19], {16'd7, 16'(exp_leak(16'sd7))});
        rst = 1'b0;
        run_sweep(0, 121, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
